display_arbiter: RTL and testbench
==================================

// Module: display_arbiter
// PURPOSE
//  Shares the two-digit 7-seg display among NUM_REQ requesters (score, countdown, game timer, status flash).
//  Fixed priority: higher index wins, with a minimum-hold anti-flicker rule and one-shot timed flash overlays.
//  Sits between the game FSM/counters and the 7-seg driver; outputs one 0..99 value plus a blank control.
// PARAMETERS
//  NUM_REQ      4     number of requesters (2..8); index NUM_REQ-1 = highest priority
//  MIN_HOLD     500   ticks an owner keeps the display before a higher-priority req may preempt (0 = immediate)
//  FLASH_TICKS  1000  ticks a flash overlay is shown (>=1)
//  BLINK_TICKS  250   blink half-period in ticks (used only with DISP_ARB_BLINK_EN)
// PORTS
//  clk         in   1            system clock
//  reset       in   1            synchronous, active-high
//  tick        in   1            1 kHz single-cycle enable; all hold/flash timing counts tick cycles
//  req         in   NUM_REQ      level request per requester
//  req_val     in   7*NUM_REQ    value of requester i in bits [7i+6:7i]
//  flash       in   NUM_REQ      single-cycle pulse: show requester i's value for FLASH_TICKS
//  disp_value  out  7            value to display, saturated to 99
//  disp_on     out  1            1 = digits lit, 0 = blank
//  grant       out  NUM_REQ      one-hot current owner, 0 when IDLE
//  in_flash    out  1            1 while in FLASH
// BEHAVIOUR
//  Reset: state=IDLE, disp_value=0, disp_on=0, grant=0, in_flash=0, pending flashes cleared, counters 0.
//  All outputs registered; a decision made from cycle-N inputs is visible at cycle N+1.
//  States: IDLE (blank), OWN (live value of owner), FLASH (latched value of flash source).
//  IDLE: highest pending flash -> FLASH; else highest active req -> OWN with hold_cnt=0; else stay.
//  OWN: hold_cnt += 1 on tick, saturating at MIN_HOLD; disp_value tracks owner's req_val every cycle.
//   - owner req drops -> highest other active req (hold_cnt=0), else IDLE; hold rule ignored.
//   - higher-index req active and hold_cnt==MIN_HOLD -> switch to highest such, hold_cnt=0.
//   - lower-index reqs never preempt; any flash pulse -> FLASH immediately (flash beats hold).
//  FLASH: value latched from req_val[src] on the pulse cycle; req[src] need not be asserted.
//   - flash_cnt += 1 on tick; at FLASH_TICKS -> next pending flash, else IDLE-rule selection.
//   - new flash pulse with index > src: preempt, restart flash_cnt, re-latch; old src is dropped.
//   - new pulse with index == src: restart flash_cnt, re-latch value.
//   - new pulse with index < src: set pending bit i; serviced later in priority order.
//  Simultaneous pulses: highest index taken, others become pending; duplicate pending bits merge.
//  A pulse arriving on the same cycle as flash expiry counts as pending and is taken at expiry.
//  tick coincident with a state switch: the new owner's counter starts at 0, and that tick is not counted.
//  Saturation: any req_val > 99 is output as 99. disp_on=1 in OWN/FLASH, 0 in IDLE.
//  Mid-operation reset: returns to reset state next cycle; pending flashes are lost.
// CONFIGURATION
//  DISP_ARB_BLINK_EN defined: in FLASH, disp_on toggles every BLINK_TICKS ticks, starting at 1 on entry/restart;
//   forced back to 1 on leaving FLASH.
//  Not defined: disp_on is steady 1 in FLASH; BLINK_TICKS is unused and no blink counter is built.
// TESTING (defaults)
//  req=0001, val0=42 -> 1 cycle later grant=0001, disp_value=42, disp_on=1; drop req -> IDLE, disp_on=0.
//  owner 0 for 100 ticks, assert req[2] (val2=30) -> no switch until tick 500, then grant=0100, disp_value=30.
//  owner 2, pulse flash[1] with val1=3 -> in_flash=1, disp_value=3 for 1000 ticks, then back to owner 2.
//  flash[0] and flash[3] in the same cycle -> flash 3 for 1000 ticks, then flash 0 for 1000 ticks, then req-based owner.
//  req_val=120 -> disp_value=99; reset asserted mid-FLASH -> next cycle all outputs 0, pending bits cleared.
//  BLINK_EN build: flash[1] -> disp_on 1 for 250 ticks, 0 for 250, 1, 0, then exits FLASH with disp_on=1.

Source files
------------

// File: rtl/display_arbiter.sv
// display_arbiter: fixed-priority sharing of a two-digit display with min-hold preemption and timed flash overlays.
// Define DISP_ARB_BLINK_EN to blink the digits while a flash overlay is shown.
module display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MIN_HOLD    = 500,
    parameter int FLASH_TICKS = 1000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_val,
    input  logic [NUM_REQ-1:0]   flash,
    output logic [6:0]           disp_value,
    output logic                 disp_on,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 in_flash
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MIN_HOLD + 2);
    localparam int FW = $clog2(FLASH_TICKS + 1);

    typedef enum logic [1:0] {IDLE, OWN, FLASH} state_t;

    state_t             state, state_n;
    logic [IW-1:0]      owner, owner_n, src, src_n, hi, pa_top, rq_top;
    logic [HW-1:0]      hold_cnt, hold_n;
    logic [FW-1:0]      flash_cnt, flash_n;
    logic [NUM_REQ-1:0] pending, pend_n, pend_all, above;
    logic [6:0]         val_n;
    logic               on_n, sel, restart, hold_max, expire;

    function automatic logic [IW-1:0] top(input logic [NUM_REQ-1:0] v);
        top = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (v[i]) top = IW'(i);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
        return NUM_REQ'(1) << i;
    endfunction

    function automatic logic [6:0] sat(input logic [6:0] v);
        return v > 7'd99 ? 7'd99 : v;
    endfunction

    assign pend_all = pending | flash;
    assign hi       = top(flash);
    assign pa_top   = top(pend_all);
    assign rq_top   = top(req);
    assign above    = ~((NUM_REQ'(2) << owner) - NUM_REQ'(1));
    assign hold_max = hold_cnt == HW'(MIN_HOLD);
    assign expire   = tick && flash_cnt == FW'(FLASH_TICKS - 1);

`ifdef DISP_ARB_BLINK_EN
    localparam int BW = $clog2(BLINK_TICKS + 1);
    logic [BW-1:0] blink_cnt, blink_n;
    logic          keep, toggle;
    assign keep   = state == FLASH && !sel && !restart;
    assign toggle = tick && blink_cnt == BW'(BLINK_TICKS - 1);
    assign blink_n = !keep ? '0 : toggle ? '0 : blink_cnt + BW'(tick);
    assign on_n   = keep ? disp_on ^ toggle : state_n != IDLE;
    always_ff @(posedge clk)
        blink_cnt <= reset ? '0 : blink_n;
`else
    assign on_n = state_n != IDLE;
`endif

    always_comb begin
        state_n = state;
        owner_n = owner;
        src_n   = src;
        hold_n  = hold_cnt;
        flash_n = flash_cnt;
        pend_n  = pending;
        val_n   = disp_value;
        restart = 1'b0;
        sel     = 1'b1;
        if (state == OWN) begin
            sel    = flash != '0 || !req[owner] || ((req & above) != '0 && hold_max);
            hold_n = (tick && !hold_max) ? hold_cnt + HW'(1) : hold_cnt;
            val_n  = sat(req_val[7*owner +: 7]);
        end else if (state == FLASH) begin
            // an equal-or-higher pulse restarts the overlay; lower ones wait in pending
            restart = flash != '0 && hi >= src;
            sel     = expire;
            pend_n  = pending | (flash & ~(restart ? onehot(hi) : {NUM_REQ{1'b0}}));
            src_n   = restart ? hi : src;
            flash_n = restart ? '0 : flash_cnt + FW'(tick);
            val_n   = restart ? sat(req_val[7*hi +: 7]) : disp_value;
        end
        if (sel) begin
            if (pend_all != '0) begin
                state_n = FLASH;
                src_n   = pa_top;
                pend_n  = pend_all & ~onehot(pa_top);
                flash_n = '0;
                val_n   = sat(req_val[7*pa_top +: 7]);
            end else if (req != '0) begin
                state_n = OWN;
                owner_n = rq_top;
                hold_n  = '0;
                pend_n  = '0;
                val_n   = sat(req_val[7*rq_top +: 7]);
            end else begin
                state_n = IDLE;
                pend_n  = '0;
                val_n   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            src        <= '0;
            hold_cnt   <= '0;
            flash_cnt  <= '0;
            pending    <= '0;
            disp_value <= '0;
            disp_on    <= 1'b0;
            grant      <= '0;
            in_flash   <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            src        <= src_n;
            hold_cnt   <= hold_n;
            flash_cnt  <= flash_n;
            pending    <= pend_n;
            disp_value <= val_n;
            disp_on    <= on_n;
            grant      <= state_n == OWN ? onehot(owner_n) : '0;
            in_flash   <= state_n == FLASH;
        end
    end
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed checks of ownership, min-hold, flash overlays, saturation and reset.
module tb_display_arbiter;
    logic        clk = 1'b0, reset = 1'b1, tick = 1'b0;
    logic [3:0]  req = '0, flash = '0, grant;
    logic [27:0] req_val = '0;
    logic [6:0]  disp_value;
    logic        disp_on, in_flash;
    int          n_chk = 0, n_fail = 0;

    display_arbiter dut (
        .clk(clk), .reset(reset), .tick(tick), .req(req), .req_val(req_val),
        .flash(flash), .disp_value(disp_value), .disp_on(disp_on),
        .grant(grant), .in_flash(in_flash)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    task automatic set_val(input int i, input logic [6:0] v);
        req_val[7*i +: 7] = v;
    endtask

    initial begin
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_value", disp_value, 0);
        check("rst_on", disp_on, 0);
        check("rst_grant", grant, 0);
        check("rst_flash", in_flash, 0);

        set_val(0, 42);
        req = 4'b0001;
        cyc();
        check("own0_grant", grant, 1);
        check("own0_value", disp_value, 42);
        check("own0_on", disp_on, 1);
        set_val(0, 55);
        cyc();
        check("own0_track", disp_value, 55);
        req = 4'b0000;
        cyc();
        check("drop_grant", grant, 0);
        check("drop_on", disp_on, 0);

        req = 4'b0001;
        cyc();
        ticks(100);
        set_val(2, 30);
        req = 4'b0101;
        ticks(399);
        check("hold_499_grant", grant, 1);
        ticks(1);
        check("hold_500_grant", grant, 4);
        check("hold_500_value", disp_value, 30);
        ticks(600);
        check("low_no_preempt", grant, 4);
        req = 4'b0100;

        set_val(1, 3);
        flash = 4'b0010;
        cyc();
        flash = 4'b0000;
        set_val(1, 9);
        check("fl1_in", in_flash, 1);
        check("fl1_value", disp_value, 3);
        check("fl1_grant", grant, 0);
        ticks(999);
        check("fl1_999_in", in_flash, 1);
        check("fl1_latched", disp_value, 3);
`ifndef DISP_ARB_BLINK_EN
        check("fl1_steady_on", disp_on, 1);
`endif
        ticks(1);
        check("fl1_exit_in", in_flash, 0);
        check("fl1_exit_grant", grant, 4);
        check("fl1_exit_value", disp_value, 30);
        set_val(2, 120);
        cyc();
        check("sat_value", disp_value, 99);

        set_val(0, 7);
        set_val(3, 88);
        flash = 4'b1001;
        cyc();
        flash = 4'b0000;
        check("sim_first", disp_value, 88);
        ticks(999);
        check("sim_first_hold", disp_value, 88);
        ticks(1);
        check("sim_second_in", in_flash, 1);
        check("sim_second_value", disp_value, 7);
        ticks(999);
        check("sim_second_hold", in_flash, 1);
        ticks(1);
        check("sim_done_in", in_flash, 0);
        check("sim_done_grant", grant, 4);
        check("sim_done_value", disp_value, 99);

        set_val(1, 20);
        flash = 4'b0010;
        cyc();
        flash = 4'b0000;
        ticks(500);
        set_val(1, 11);
        flash = 4'b0010;
        cyc();
        check("restart_value", disp_value, 11);
        flash = 4'b0001;
        cyc();
        flash = 4'b0000;
        check("lowpend_value", disp_value, 11);
        ticks(999);
        check("restart_hold", in_flash, 1);
        ticks(1);
        check("pend_taken_value", disp_value, 7);
        check("pend_taken_in", in_flash, 1);

        flash = 4'b0100;
        cyc();
        check("preempt_value", disp_value, 99);
        flash = 4'b0010;
        cyc();
        flash = 4'b0000;
        req = 4'b0000;
        check("pend_low_value", disp_value, 99);
        reset = 1'b1;
        cyc();
        check("midrst_value", disp_value, 0);
        check("midrst_on", disp_on, 0);
        check("midrst_flash", in_flash, 0);
        check("midrst_grant", grant, 0);
        reset = 1'b0;
        cyc();
        check("pend_cleared", in_flash, 0);
        check("pend_cleared_on", disp_on, 0);

`ifdef DISP_ARB_BLINK_EN
        set_val(2, 30);
        req = 4'b0100;
        cyc();
        set_val(1, 5);
        flash = 4'b0010;
        cyc();
        flash = 4'b0000;
        check("blink_entry", disp_on, 1);
        ticks(249);
        check("blink_249", disp_on, 1);
        ticks(1);
        check("blink_250", disp_on, 0);
        ticks(250);
        check("blink_500", disp_on, 1);
        ticks(250);
        check("blink_750", disp_on, 0);
        ticks(250);
        check("blink_exit_on", disp_on, 1);
        check("blink_exit_in", in_flash, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
